// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg
//   Shared helpers for the fixed-point adder/subtractor family:
//   max function, derived internal widths and saturation-limit generator.
package fixed_point_pkg;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Common integer width (sign included) after aligning two operands.
  function automatic int int_len(input int wi1, input int wi2);
    return max_of(wi1, wi2);
  endfunction

  // Common fraction width after aligning two operands.
  function automatic int frc_len(input int wf1, input int wf2);
    return max_of(wf1, wf2);
  endfunction

  // One guard bit above the aligned width makes add/sub exact.
  function automatic int full_width(input int il, input int fl);
    return il + fl + 1;
  endfunction

  // Two's-complement clamp values for a w-bit result (low w bits valid):
  // negative = 1 followed by 0s, positive = 0 followed by 1s.
  function automatic logic [63:0] sat_limit(input int w, input bit negative);
    if (negative)
      return 64'd1 << (w - 1);
    else
      return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/fixed_point_align.sv
// fixed_point_align
//   Aligns one signed fixed-point operand Q(WI).(WF) to Q(IL).(FL):
//   sign-extends the integer part and zero-pads the fraction LSBs.
// Ports:
//   din  : [WI+WF-1:0] operand in its native format
//   dout : [IL+FL-1:0] aligned operand (IL >= WI, FL >= WF)
module fixed_point_align #(
  parameter int WI = 3,
  parameter int WF = 4,
  parameter int IL = 4,
  parameter int FL = 4
) (
  input  logic [WI+WF-1:0] din,
  output logic [IL+FL-1:0] dout
);

  // Sign-extend to the full aligned width, then shift left to move the
  // binary point; the vacated LSBs are the zero-padded fraction bits.
  assign dout = (IL + FL)'($signed(din)) <<< (FL - WF);

endmodule

// File: rtl/fixed_point_subtractor_pipelined.sv
// fixed_point_subtractor_pipelined
//   Two-stage valid/ready pipeline computing input1 - input2 for signed
//   fixed-point operands Q(WI1).(WF1) and Q(WI2).(WF2), re-quantised to
//   Q(WIO).(WFO) with an overflow flag.
//   Optional macro FIXED_POINT_SUB_SATURATE_EN: clamp on overflow instead
//   of wrapping.
// Ports:
//   clk, reset          : rising-edge clock, async active-high reset
//   in_valid / in_ready : operand handshake
//   input1, input2      : minuend / subtrahend
//   out_valid/out_ready : result handshake
//   FixedPoint_Sub_Out  : difference, Q(WIO).(WFO)
//   overFlow            : result not representable (qualified by out_valid)
module fixed_point_subtractor_pipelined
  import fixed_point_pkg::*;
#(
  parameter int WI1 = 3,
  parameter int WF1 = 4,
  parameter int WI2 = 4,
  parameter int WF2 = 3,
  parameter int WIO = max_of(WI1, WI2) + 1,
  parameter int WFO = max_of(WF1, WF2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   input1,
  input  logic [WI2+WF2-1:0]   input2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   FixedPoint_Sub_Out,
  output logic                 overFlow
);

  localparam int IL = int_len(WI1, WI2);
  localparam int FL = frc_len(WF1, WF2);
  localparam int AL = IL + FL;
  localparam int FW = full_width(IL, FL);
  localparam int SW = IL + 1 + WFO;   // diff rescaled to WFO fraction bits
  localparam int OW = WIO + WFO;

  logic [AL-1:0]        al1, al2;
  logic signed [AL-1:0] op1_q, op2_q;
  logic                 s1_valid;
  logic                 s1_load, s2_load;
  logic signed [FW-1:0] diff;
  logic signed [SW-1:0] scaled;
  logic [OW-1:0]        res_n;
  logic                 ovf_n;

  fixed_point_align #(.WI(WI1), .WF(WF1), .IL(IL), .FL(FL)) u_align1 (
    .din (input1),
    .dout(al1)
  );

  fixed_point_align #(.WI(WI2), .WF(WF2), .IL(IL), .FL(FL)) u_align2 (
    .din (input2),
    .dout(al2)
  );

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      op1_q    <= al1;
      op2_q    <= al2;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  assign diff = FW'(op1_q) - FW'(op2_q);

  // Fraction re-quantisation: arithmetic right shift truncates toward -inf.
  generate
    if (WFO >= FL) begin : g_frc_pad
      assign scaled = SW'(diff) <<< (WFO - FL);
    end else begin : g_frc_trunc
      logic signed [FW-1:0] shifted;
      assign shifted = diff >>> (FL - WFO);
      assign scaled  = SW'(shifted);
    end
  endgenerate

  generate
    if (OW >= SW) begin : g_int_ext
      assign res_n = OW'(scaled);
      assign ovf_n = 1'b0;
    end else begin : g_int_trunc
      // Bits above the retained sign must all match it for a faithful result.
      logic [SW-OW:0] upper;
      logic [OW-1:0]  wrapped;
      assign upper   = scaled[SW-1:OW-1];
      assign wrapped = scaled[OW-1:0];
      assign ovf_n   = !((&upper) || !(|upper));
`ifdef FIXED_POINT_SUB_SATURATE_EN
      localparam logic [OW-1:0] SAT_POS = OW'(sat_limit(OW, 1'b0));
      localparam logic [OW-1:0] SAT_NEG = OW'(sat_limit(OW, 1'b1));
      assign res_n = !ovf_n ? wrapped : (diff[FW-1] ? SAT_NEG : SAT_POS);
`else
      assign res_n = wrapped;
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid          <= 1'b0;
      FixedPoint_Sub_Out <= '0;
      overFlow           <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        FixedPoint_Sub_Out <= res_n;
        overFlow           <= ovf_n;
      end
    end
  end

endmodule
